uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clock cycles per bit period; legal range >= 2.
REQ-002 SHALL provide parameter PARITY_EN, default 0, 1 = insert parity bit after data bits.
REQ-003 SHALL provide parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-004 SHALL provide parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tx_data  input  8  byte to transmit; sampled only on handshake.
REQ-008 tx_valid  input  1  producer (FIFO read side) offers tx_data.
REQ-009 tx_ready  output  1  block can accept a byte this cycle.
REQ-010 tx  output  1  serial line; idle high; registered.
REQ-011 busy  output  1  frame in progress (any state other than IDLE).
REQ-012 tx_done  output  1  one-cycle pulse marking completion of a frame.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_EN = 0.
REQ-014 tx_ready SHALL equal 1 exactly when the state is IDLE; busy SHALL equal the inverse of tx_ready.
REQ-015 Handshake: a byte SHALL be accepted on a rising edge where tx_valid = 1 and tx_ready = 1; tx_data latched into an internal 8-bit shift register on that edge.
REQ-016 tx_valid while tx_ready = 0 SHALL be ignored; changes to tx_data after acceptance SHALL have no effect on the frame in progress.
REQ-017 The start bit (tx = 0) SHALL begin in the cycle after acceptance.
REQ-018 Every bit (start, data, parity, stop) SHALL hold for exactly CLKS_PER_BIT cycles, timed by an internal counter of width clog2(CLKS_PER_BIT) that restarts at each bit boundary.
REQ-019 Data bits SHALL be sent LSB first, 8 bits, using a 3-bit bit index that terminates DATA after index 7.
REQ-020 The parity bit SHALL be the XOR of the 8 latched data bits for even parity, or its inverse for odd parity.
REQ-021 STOP SHALL drive tx = 1 for STOP_BITS x CLKS_PER_BIT cycles.
REQ-022 After STOP, the FSM SHALL enter IDLE. In that first IDLE cycle, tx_done = 1, tx_ready = 1 and tx = 1.
REQ-023 Frame length from the start-bit cycle to the last stop cycle SHALL be (1 + 8 + PARITY_EN + STOP_BITS) x CLKS_PER_BIT cycles.
REQ-024 Back-to-back: with tx_valid held high, the next byte SHALL be accepted in the first IDLE cycle. This leaves exactly one idle-high cycle between the last stop cycle and the next start bit.
REQ-025 tx SHALL be driven from a flop with no combinational path from the inputs.

Reset
REQ-026 On rst = 1, regardless of clk and of the current state, the block SHALL immediately set state = IDLE, tx = 1, tx_done = 0, and clear the bit counter, bit index and shift register.
REQ-027 tx_ready SHALL read 1 and busy SHALL read 0 while in reset and after reset is released.
REQ-028 Reset mid-frame SHALL abandon the frame with no further bits emitted. The first handshake after release SHALL produce a complete, correct frame.

Verification (CLKS_PER_BIT = 4; acceptance edge = cycle 0)
REQ-029 Byte 0xA5, no parity, STOP_BITS=1 -> tx SHALL read 0 for cycles 1-4, then data bits 1,0,1,0,0,1,0,1 for 4 cycles each (cycles 5-36), then 1 for cycles 37-40. In cycle 41, tx_done = 1 and tx_ready = 1.
REQ-030 Byte 0x07, PARITY_EN=1 -> parity bit in cycles 37-40 SHALL be 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1. Stop bit in cycles 41-44; tx_done in cycle 45.
REQ-031 STOP_BITS=2, byte 0x00 -> tx SHALL be 0 for cycles 1-36 and 1 for cycles 37-44. tx_done SHALL pulse in cycle 45 only.
REQ-032 Back-to-back 0x55 then 0xAA with tx_valid held -> second acceptance in cycle 41 and tx = 1 in cycle 41 only. Second start bit in cycles 42-45. The 0xAA data bits SHALL read 0,1,0,1,0,1,0,1.
REQ-033 tx_valid pulsed with 0xFF during data bits of a 0x00 frame -> frame SHALL be unchanged, with no second frame and exactly one tx_done.
REQ-034 rst asserted asynchronously during data bit 3 of 0x3C -> tx = 1 and busy = 0 in the same cycle as reset assertion. A subsequent 0x3C frame after release SHALL match the REQ-029 timing.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter. It accepts a byte through a valid/ready
// handshake and sends it as an 8N1-style frame: start bit, 8 data bits LSB
// first, an optional parity bit, then one or two stop bits.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, ready for a byte; first IDLE cycle flags tx_done
// START  | driving the start bit (low)
// DATA   | shifting out data bits 0..7, LSB first
// PARITY | driving the parity bit (only when PARITY_EN = 1)
// STOP   | driving STOP_BITS stop bits (high)
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic           PAR_INV   = (PARITY_ODD != 0);
  localparam logic           PAR_ON    = (PARITY_EN != 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  // The bit counter counts down; zero marks the last cycle of the current bit.
  logic bit_end;
  assign bit_end = (cnt_q == '0);

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance only at bit boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (tx_valid) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && idx_q == 3'd7) state_d = PAR_ON ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end && idx_q == STOP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The shift register rotates instead of shifting so
  // that after the eighth data bit it holds the original byte again, which
  // lets the parity bit be computed from it directly.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shift_d = tx_data;
          cnt_d   = CNT_LOAD;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = CNT_LOAD;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {shift_q[0], shift_q[7:1]};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = CNT_LOAD;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            tx_d  = PAR_ON ? ((^shift_q) ^ PAR_INV) : 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {shift_q[0], shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d = CNT_LOAD;
          idx_d = 3'd0;
          tx_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d  = 3'd0;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = CNT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

  // Datapath registers; tx and tx_done come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Handshake status decoded from the state.
  always_comb begin
    tx_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  assign tx      = tx_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances with different framing options share one
// stimulus stream; each is compared cycle by cycle against a bit-list model.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int NCYC = 50;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] tx_w, rdy_w, busy_w, done_w;

  int n_checks = 0;
  int n_err    = 0;

  logic cap_tx   [4][NCYC+1];
  logic cap_rdy  [4][NCYC+1];
  logic cap_busy [4][NCYC+1];
  logic cap_done [4][NCYC+1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  // ---------------- reference model ----------------
  function automatic int pen(input int inst);
    return (inst == 1 || inst == 2) ? 1 : 0;
  endfunction
  function automatic logic pod(input int inst);
    return (inst == 2);
  endfunction
  function automatic int nstop(input int inst);
    return (inst == 3) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int inst);
    return (1 + 8 + pen(inst) + nstop(inst)) * CPB;
  endfunction

  // Expected line level c cycles after the acceptance edge (c = 1 is the
  // first start-bit cycle); outside the frame the line idles high.
  function automatic logic model_tx(input int inst, input logic [7:0] d, input int c);
    int b;
    if (c < 1 || c > frame_len(inst)) return 1'b1;
    b = (c - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pen(inst) == 1 && b == 9) return (^d) ^ pod(inst);
    return 1'b1;
  endfunction
  function automatic logic model_done(input int inst, input int c);
    return (c == frame_len(inst) + 1);
  endfunction
  function automatic logic model_rdy(input int inst, input int c);
    return (c > frame_len(inst));
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Offer byte d for one handshake (all instances idle), then record NCYC
  // cycles. tx_data is scrambled after acceptance; if inj > 0 an extra
  // tx_valid pulse with 0xFF is applied during cycle inj.
  task automatic run_frame(input logic [7:0] d, input int inj);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = ~d;
    for (int k = 1; k <= NCYC; k++) begin
      for (int i = 0; i < 4; i++) begin
        cap_tx[i][k]   = tx_w[i];
        cap_rdy[i][k]  = rdy_w[i];
        cap_busy[i][k] = busy_w[i];
        cap_done[i][k] = done_w[i];
      end
      if (k == inj) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end else begin
        tx_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] d);
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= NCYC; k++) begin
        chk($sformatf("tx inst%0d byte%02h cyc%0d", i, d, k), cap_tx[i][k], model_tx(i, d, k));
        chk($sformatf("done inst%0d byte%02h cyc%0d", i, d, k), cap_done[i][k], model_done(i, k));
        chk($sformatf("ready inst%0d byte%02h cyc%0d", i, d, k), cap_rdy[i][k], model_rdy(i, k));
        chk($sformatf("busy inst%0d byte%02h cyc%0d", i, d, k), cap_busy[i][k], ~model_rdy(i, k));
      end
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         inst;
    int         cyc;
    logic       etx;
    logic       edone;
    logic       erdy;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [7:0] rd;
    int         inj;
    logic       exp_tx, exp_done, exp_rdy;

    tbl[0]  = '{8'hA5, 0,  1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'hA5, 0,  4, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'hA5, 0,  5, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{8'hA5, 0,  9, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'hA5, 0, 36, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{8'hA5, 0, 37, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{8'hA5, 0, 40, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{8'hA5, 0, 41, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{8'hA5, 0, 42, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{8'h07, 1, 37, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{8'h07, 1, 41, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{8'h07, 1, 45, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{8'h07, 2, 37, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{8'h07, 2, 40, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{8'h00, 3, 36, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{8'h00, 3, 37, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{8'h00, 3, 44, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{8'h00, 3, 45, 1'b1, 1'b1, 1'b1};

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset tx inst%0d", i), tx_w[i], 1'b1);
      chk($sformatf("reset ready inst%0d", i), rdy_w[i], 1'b1);
      chk($sformatf("reset busy inst%0d", i), busy_w[i], 1'b0);
      chk($sformatf("reset done inst%0d", i), done_w[i], 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post-reset ready inst%0d", i), rdy_w[i], 1'b1);
      chk($sformatf("post-reset tx inst%0d", i), tx_w[i], 1'b1);
    end

    // Directed spot checks from the frame timing table.
    for (int v = 0; v < 18; v++) begin
      if (v == 0 || tbl[v].d != tbl[v-1].d) run_frame(tbl[v].d, 0);
      chk($sformatf("vec%0d tx", v), cap_tx[tbl[v].inst][tbl[v].cyc], tbl[v].etx);
      chk($sformatf("vec%0d done", v), cap_done[tbl[v].inst][tbl[v].cyc], tbl[v].edone);
      chk($sformatf("vec%0d ready", v), cap_rdy[tbl[v].inst][tbl[v].cyc], tbl[v].erdy);
    end

    // Extra tx_valid pulse during the data bits must be ignored.
    run_frame(8'h00, 12);
    check_frame(8'h00);

    // Back-to-back 0x55 then 0xAA with tx_valid held on instance A.
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hAA;
    for (int k = 1; k <= 88; k++) begin
      if (k <= 41) begin
        exp_tx   = model_tx(0, 8'h55, k);
        exp_done = model_done(0, k);
        exp_rdy  = model_rdy(0, k);
      end else begin
        exp_tx   = model_tx(0, 8'hAA, k - 41);
        exp_done = model_done(0, k - 41);
        exp_rdy  = model_rdy(0, k - 41);
      end
      chk($sformatf("b2b tx cyc%0d", k), tx_w[0], exp_tx);
      chk($sformatf("b2b done cyc%0d", k), done_w[0], exp_done);
      chk($sformatf("b2b ready cyc%0d", k), rdy_w[0], exp_rdy);
      if (k >= 42) tx_valid = 1'b0;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;

    // Reset asserted asynchronously during data bit 3 of 0x3C.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("pre-reset busy", busy_w[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("async reset tx inst%0d", i), tx_w[i], 1'b1);
      chk($sformatf("async reset busy inst%0d", i), busy_w[i], 1'b0);
      chk($sformatf("async reset ready inst%0d", i), rdy_w[i], 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abandoned tx cyc%0d", k), tx_w[0], 1'b1);
      chk($sformatf("abandoned busy cyc%0d", k), busy_w[0], 1'b0);
    end
    run_frame(8'h3C, 0);
    check_frame(8'h3C);

    // Random bytes, sometimes with a stray tx_valid pulse mid-frame.
    for (int r = 0; r < 10; r++) begin
      rd  = 8'($urandom);
      inj = $urandom_range(0, 35);
      run_frame(rd, inj);
      check_frame(rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
